// File: rtl/q3_deser_pkg.sv
// Shared definitions for the q3 deserializer: default word width, buffer depth
// and the output buffer state encoding.
package q3_deser_pkg;

  localparam int Q3_W_DEF     = 8;
  localparam int Q3_DEPTH_DEF = 2;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/q3_deser_if.sv
// Serial-in / word-out bundle between the q3 stage, the deserializer and its consumer.
interface q3_deser_if
  import q3_deser_pkg::*;
#(
  parameter int W = Q3_W_DEF
);
  logic                     i;
  logic                     en;
  logic                     dready;
  logic [W-1:0]             dout;
  logic                     dvalid;
  logic [$clog2(W+1)-1:0]   ones;
  logic                     ovf;

  modport master (output i, output en, output dready,
                  input dout, input dvalid, input ones, input ovf);
  modport slave  (input i, input en, input dready,
                  output dout, output dvalid, output ones, output ovf);
endinterface

// File: rtl/q3_deser_fifo2.sv
// Two-entry in-order buffer; entry 0 is always the head so rdata comes straight from a flop.
//   state     | meaning
//   BUF_EMPTY | no word held, head cleared to 0
//   BUF_ONE   | head valid, tail unused
//   BUF_FULL  | head and tail valid; push without pop is discarded
module q3_fifo2
  import q3_deser_pkg::*;
#(
  parameter int DW = 12
) (
  input  logic          c,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          empty,
  output logic          full
);

  buf_state_e    state_q, state_d;
  logic [DW-1:0] e0_q, e0_d;
  logic [DW-1:0] e1_q, e1_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;

  always_comb begin
    state_d = state_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    unique case (state_q)
      BUF_EMPTY: begin
        if (push) begin
          e0_d    = wdata;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (push && pop) begin
          e0_d = wdata;
        end else if (push) begin
          e1_d    = wdata;
          state_d = BUF_FULL;
        end else if (pop) begin
          e0_d    = '0;
          state_d = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        // Without a pop the incoming word is simply not stored.
        if (pop) begin
          e0_d = e1_q;
          if (push) begin
            e1_d = wdata;
          end else begin
            e1_d    = '0;
            state_d = BUF_ONE;
          end
        end
      end
      default: begin
        e0_d    = '0;
        e1_d    = '0;
        state_d = BUF_EMPTY;
      end
    endcase
    empty_d = (state_d == BUF_EMPTY);
    full_d  = (state_d == BUF_FULL);
  end

  always_ff @(posedge c) begin
    if (rst) begin
      state_q <= BUF_EMPTY;
      e0_q    <= '0;
      e1_q    <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  assign rdata = e0_q;
  assign empty = empty_q;
  assign full  = full_q;

endmodule

// File: rtl/q3_deser.sv
// LSB-first serial-to-parallel converter with a two-word output buffer,
// per-word population count and a sticky overflow flag.
module q3_deser
  import q3_deser_pkg::*;
#(
  parameter int W     = Q3_W_DEF,
  parameter int DEPTH = Q3_DEPTH_DEF
) (
  input  logic       c,
  input  logic       rst,
  q3_deser_if.slave  bus
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int OW = $clog2(W + 1);
  localparam int EW = W + OW;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  sh_q, sh_d;
  logic [W-1:0]  shifted;
  logic          ovf_q, ovf_d;
  logic          push, pop;
  logic [OW-1:0] ones_w;
  logic [EW-1:0] rdata;
  logic          empty, full;

  always_comb begin
    // The completed word already includes the bit arriving on this edge.
    shifted = {bus.i, sh_q[W-1:1]};
    ones_w  = '0;
    for (int k = 0; k < W; k++) begin
      ones_w = ones_w + OW'(shifted[k]);
    end

    sh_d  = sh_q;
    cnt_d = cnt_q;
    push  = 1'b0;
    if (bus.en) begin
      sh_d = shifted;
      if (cnt_q == CW'(W - 1)) begin
        cnt_d = '0;
        push  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    pop   = ~empty & bus.dready;
    ovf_d = ovf_q | (push & full & ~pop);
  end

  always_ff @(posedge c) begin
    if (rst) begin
      cnt_q <= '0;
      sh_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sh_q  <= sh_d;
      ovf_q <= ovf_d;
    end
  end

  if (DEPTH == 2) begin : g_buf
    q3_fifo2 #(.DW(EW)) u_fifo (
      .c     (c),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata ({ones_w, shifted}),
      .rdata (rdata),
      .empty (empty),
      .full  (full)
    );
  end else begin : g_nobuf
    assign rdata = '0;
    assign empty = 1'b1;
    assign full  = 1'b1;
  end

  // The buffer clears its head when it empties, so dout/ones read 0 with dvalid=0.
  assign bus.dout   = rdata[W-1:0];
  assign bus.ones   = rdata[EW-1:W];
  assign bus.dvalid = ~empty;
  assign bus.ovf    = ovf_q;

endmodule
